// File: rtl/if_id_pipe_ctrl.sv
// Front-end pipeline controller: owns the PC, the IF/ID register and the ID/EX
// control word, applying hazard-unit stalls and ID-stage redirects.
module if_id_pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 10,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              IFID_write,
  input  logic              hazard,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       imem_addr,
  output logic [31:0]       ifid_inst,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        stall;
  logic        redirect;

  // A branch seen during any stall may have stale operands, so it is only
  // accepted once it is re-presented on a clean cycle.
  assign stall          = ~hazard | ~pc_write | ~IFID_write;
  assign redirect       = branch_taken & ~stall;
  assign pc_plus4       = pc + 32'd4;
  assign target_aligned = branch_target & ~32'h0000_0003;
  assign imem_addr      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ifid_inst   <= '0;
      ifid_pc4    <= '0;
      ifid_valid  <= 1'b0;
      idex_ctrl   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_write) begin
        pc <= redirect ? target_aligned : pc_plus4;
      end

      if (IFID_write) begin
        if (redirect) begin
          ifid_inst  <= '0;
          ifid_pc4   <= '0;
          ifid_valid <= 1'b0;
        end else begin
          ifid_inst  <= imem_inst;
          ifid_pc4   <= pc_plus4;
          ifid_valid <= 1'b1;
        end
      end

      // Bubbles and flushed slots both reach EX as an all-zero control word.
      idex_ctrl <= (hazard & ifid_valid) ? id_ctrl : '0;

      if (!hazard && stall_count != '1) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (redirect && flush_count != '1) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// Self-checking bench for if_id_pipe_ctrl: table-driven vectors whose expected
// outputs go through a scoreboard queue, plus saturation and reset sequences.
module tb_if_id_pipe_ctrl;

  localparam int CTRL_W = 10;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              pc_write;
  logic              IFID_write;
  logic              hazard;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       imem_inst;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       imem_addr;
  logic [31:0]       ifid_inst;
  logic [31:0]       ifid_pc4;
  logic              ifid_valid;
  logic [CTRL_W-1:0] idex_ctrl;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  typedef struct {
    string             name;
    logic              rst;
    logic              pw;
    logic              iw;
    logic              hz;
    logic              bt;
    logic [31:0]       tgt;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       e_pc;
    logic [31:0]       e_inst;
    logic [31:0]       e_pc4;
    logic              e_valid;
    logic [CTRL_W-1:0] e_idex;
    logic [CNT_W-1:0]  e_stall;
    logic [CNT_W-1:0]  e_flush;
  } vec_t;

  vec_t vecs[$];
  vec_t scoreboard[$];

  int n_checks = 0;
  int n_fail   = 0;

  if_id_pipe_ctrl #(
    .RESET_PC (32'h0000_0000),
    .CTRL_W   (CTRL_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .IFID_write    (IFID_write),
    .hazard        (hazard),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_inst     (imem_inst),
    .id_ctrl       (id_ctrl),
    .imem_addr     (imem_addr),
    .ifid_inst     (ifid_inst),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .idex_ctrl     (idex_ctrl),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory stand-in: each address yields a distinct, non-nop word.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h2408_0000;
  endfunction

  assign imem_inst = inst_of(imem_addr);

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string name, input logic r, input logic pw, input logic iw,
                        input logic hz, input logic bt, input logic [31:0] tgt,
                        input logic [CTRL_W-1:0] ctrl, input logic [31:0] e_pc,
                        input logic [31:0] e_inst, input logic [31:0] e_pc4,
                        input logic e_valid, input logic [CTRL_W-1:0] e_idex,
                        input logic [CNT_W-1:0] e_stall, input logic [CNT_W-1:0] e_flush);
    vec_t v;
    v.name = name; v.rst = r; v.pw = pw; v.iw = iw; v.hz = hz; v.bt = bt;
    v.tgt = tgt; v.ctrl = ctrl; v.e_pc = e_pc; v.e_inst = e_inst; v.e_pc4 = e_pc4;
    v.e_valid = e_valid; v.e_idex = e_idex; v.e_stall = e_stall; v.e_flush = e_flush;
    vecs.push_back(v);
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (scoreboard.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: got empty queue expected a pending entry");
      return;
    end
    e = scoreboard.pop_front();
    checkField({e.name, ".imem_addr"},   imem_addr,          e.e_pc);
    checkField({e.name, ".ifid_inst"},   ifid_inst,          e.e_inst);
    checkField({e.name, ".ifid_pc4"},    ifid_pc4,           e.e_pc4);
    checkField({e.name, ".ifid_valid"},  32'(ifid_valid),    32'(e.e_valid));
    checkField({e.name, ".idex_ctrl"},   32'(idex_ctrl),     32'(e.e_idex));
    checkField({e.name, ".stall_count"}, 32'(stall_count),   32'(e.e_stall));
    checkField({e.name, ".flush_count"}, 32'(flush_count),   32'(e.e_flush));
  endtask

  task automatic driveInputs(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    pc_write      = v.pw;
    IFID_write    = v.iw;
    hazard        = v.hz;
    branch_taken  = v.bt;
    branch_target = v.tgt;
    id_ctrl       = v.ctrl;
    if (!v.rst && (v.pw != v.iw))
      $display("[TB] note: illegal pc_write/IFID_write combination driven in %s", v.name);
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v);
    scoreboard.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic stepOnly(input vec_t v);
    driveInputs(v);
    @(posedge clk);
  endtask

  initial begin
    vec_t s;
    rst = 1'b1; pc_write = 1'b1; IFID_write = 1'b1; hazard = 1'b1;
    branch_taken = 1'b0; branch_target = '0; id_ctrl = '0;

    //      name        rst pw iw hz bt tgt            ctrl    pc             inst                  pc4           v  idex    stl flush
    addVec("reset",     1,  1, 1, 1, 0, 32'h0,         10'h000, 32'h0,        32'h0,                32'h0,        0, 10'h000, 0, 0);
    addVec("run1",      0,  1, 1, 1, 0, 32'h0,         10'h011, 32'h4,        inst_of(32'h0),       32'h4,        1, 10'h000, 0, 0);
    addVec("run2",      0,  1, 1, 1, 0, 32'h0,         10'h022, 32'h8,        inst_of(32'h4),       32'h8,        1, 10'h022, 0, 0);
    addVec("loaduse",   0,  0, 0, 0, 0, 32'h0,         10'h033, 32'h8,        inst_of(32'h4),       32'h8,        1, 10'h000, 1, 0);
    addVec("resume",    0,  1, 1, 1, 0, 32'h0,         10'h044, 32'hC,        inst_of(32'h8),       32'hC,        1, 10'h044, 1, 0);
    addVec("br40",      0,  1, 1, 1, 1, 32'h40,        10'h055, 32'h40,       32'h0,                32'h0,        0, 10'h055, 1, 1);
    addVec("afterbr",   0,  1, 1, 1, 0, 32'h0,         10'h066, 32'h44,       inst_of(32'h40),      32'h44,       1, 10'h000, 1, 1);
    addVec("brstall",   0,  0, 0, 0, 1, 32'h80,        10'h077, 32'h44,       inst_of(32'h40),      32'h44,       1, 10'h000, 2, 1);
    addVec("brretry",   0,  1, 1, 1, 1, 32'h80,        10'h088, 32'h80,       32'h0,                32'h0,        0, 10'h088, 2, 2);
    addVec("br43",      0,  1, 1, 1, 1, 32'h43,        10'h099, 32'h40,       32'h0,                32'h0,        0, 10'h000, 2, 3);
    addVec("run3",      0,  1, 1, 1, 0, 32'h0,         10'h0AA, 32'h44,       inst_of(32'h40),      32'h44,       1, 10'h000, 2, 3);
    addVec("pwonly0",   0,  0, 1, 1, 0, 32'h0,         10'h0BB, 32'h44,       inst_of(32'h44),      32'h48,       1, 10'h0BB, 2, 3);
    addVec("iwonly0",   0,  1, 0, 1, 1, 32'h100,       10'h0CC, 32'h48,       inst_of(32'h44),      32'h48,       1, 10'h0CC, 2, 3);
    addVec("run4",      0,  1, 1, 1, 0, 32'h0,         10'h0DD, 32'h4C,       inst_of(32'h48),      32'h4C,       1, 10'h0DD, 2, 3);
    addVec("brtop",     0,  1, 1, 1, 1, 32'hFFFF_FFFF, 10'h0EE, 32'hFFFF_FFFC, 32'h0,               32'h0,        0, 10'h0EE, 2, 4);
    addVec("wrap",      0,  1, 1, 1, 0, 32'h0,         10'h0FF, 32'h0,        inst_of(32'hFFFF_FFFC), 32'h0,      1, 10'h000, 2, 4);
    addVec("afterwrap", 0,  1, 1, 1, 0, 32'h0,         10'h3FF, 32'h4,        inst_of(32'h0),       32'h4,        1, 10'h3FF, 2, 4);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Long stall run: stall_count must climb to all-ones and stay there.
    s = vecs[0];
    applyStimulus(s);
    s.name = "stall"; s.rst = 1'b0; s.pw = 1'b0; s.iw = 1'b0; s.hz = 1'b0;
    s.bt = 1'b0; s.tgt = '0; s.ctrl = 10'h155;
    s.e_pc = 32'h0; s.e_inst = '0; s.e_pc4 = '0; s.e_valid = 1'b0; s.e_idex = '0; s.e_flush = '0;
    for (int i = 0; i < 65533; i++) begin
      stepOnly(s);
    end
    s.name = "stall_fffe"; s.e_stall = 16'hFFFE;
    applyStimulus(s);
    s.name = "stall_ffff"; s.e_stall = 16'hFFFF;
    applyStimulus(s);
    for (int i = 0; i < 2; i++) begin
      stepOnly(s);
    end
    s.name = "stall_sat"; s.e_stall = 16'hFFFF;
    applyStimulus(s);

    // Reset while stalled with a branch pending: nothing may survive.
    s.name = "rst_midstall"; s.rst = 1'b1; s.bt = 1'b1; s.tgt = 32'h200; s.e_stall = '0;
    applyStimulus(s);
    s.name = "post_rst"; s.rst = 1'b0; s.pw = 1'b1; s.iw = 1'b1; s.hz = 1'b1; s.bt = 1'b0;
    s.e_pc = 32'h4; s.e_inst = inst_of(32'h0); s.e_pc4 = 32'h4; s.e_valid = 1'b1;
    s.e_idex = '0; s.e_stall = '0; s.e_flush = '0;
    applyStimulus(s);

    if (scoreboard.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_ctrl.md
Name: if_id_pipe_ctrl

Overview:
Front-end pipeline controller for the 5-stage MIPS core. It is the consumer side of the load-use hazard unit. It owns the PC register, the IF/ID pipeline register and the ID/EX control-word register. It applies the hazard unit's pc_write / IFID_write / hazard outputs (active-low stall semantics) together with ID-stage branch/jump redirects, and keeps stall and flush statistics.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CTRL_W, 10, width of the ID-stage control word passed to ID/EX
CNT_W, 16, width of the stall and flush counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc_write  in  1  from hazard unit; 1 = PC may update, 0 = hold PC
IFID_write  in  1  from hazard unit; 1 = IF/ID may load, 0 = hold IF/ID
hazard  in  1  from hazard unit; 1 = pass id_ctrl, 0 = insert bubble (zero control) into ID/EX
branch_taken  in  1  ID-stage redirect request (taken beq/bne, j, jal, jr)
branch_target  in  32  redirect address
imem_inst  in  32  instruction read combinationally at imem_addr
id_ctrl  in  CTRL_W  control word decoded in ID
imem_addr  out  32  current PC (register output)
ifid_inst  out  32  IF/ID instruction
ifid_pc4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real (non-flushed) instruction
idex_ctrl  out  CTRL_W  ID/EX control word
stall_count  out  CNT_W  cycles with hazard=0
flush_count  out  CNT_W  accepted redirects

Behaviour:
- Reset (rst=1 at edge): PC=RESET_PC; ifid_inst=0 (nop); ifid_pc4=0; ifid_valid=0; idex_ctrl=0; both counters=0. Reset overrides every other input.
- stall = ~hazard | ~pc_write | ~IFID_write.
- redirect = branch_taken & ~stall. A branch in ID during a stall cycle is not accepted; its operands may be stale. It is re-presented on the next non-stall cycle.
- PC update, in priority order:
  - ~pc_write: hold.
  - redirect: PC <= {branch_target[31:2],2'b00}. Low bits are forced to 0.
  - otherwise: PC <= PC+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update, in priority order:
  - ~IFID_write: hold all three fields.
  - redirect: flush. ifid_inst<=0, ifid_pc4<=0, ifid_valid<=0. The fetched wrong-path instruction is discarded.
  - otherwise: ifid_inst<=imem_inst, ifid_pc4<=PC+4, ifid_valid<=1.
- ID/EX control: idex_ctrl <= (hazard & ifid_valid) ? id_ctrl : 0, loaded every cycle.
  - A bubble is exactly one cycle per hazard=0 cycle.
  - Flushed slots also yield zero control.
- Latency: a PC value appears on ifid_inst/ifid_pc4 one cycle after it is on imem_addr, absent stall or redirect. Redirect-to-target fetch is 1 cycle, so each taken branch costs exactly one flushed slot.
- Illegal combination: pc_write != IFID_write. Each register still obeys its own enable per the rules above; no assertion inside the block. The bench flags it.
- stall_count increments on each cycle with hazard=0. flush_count increments on each redirect. Both saturate at all-ones and do not wrap.
- Reset mid-stall or mid-redirect: the next state is the full reset state; no pending redirect is remembered.

Test Plan:
- Reset then 4 free-running cycles, imem_inst=PC-derived → imem_addr 0,4,8,C; ifid_pc4 lags by one cycle (4,8,C); ifid_valid=1 from cycle 2; counters 0.
- Load-use: pc_write=IFID_write=hazard=0 for 1 cycle at PC=8 → PC holds 8, ifid holds the inst from addr 4, idex_ctrl=0 that cycle then id_ctrl resumes; stall_count=1.
- Branch_taken=1, target=32'h40 (hazard=1) at PC=C → next PC=40, ifid_valid=0, ifid_inst=0, following cycle idex_ctrl=0; flush_count=1.
- Branch_taken=1 coincident with hazard=0 → no redirect: PC holds, flush_count unchanged, stall_count+1. Next cycle, branch_taken=1 with hazard=1 → redirect accepted.
- Target 32'h43 → PC=40. PC at FFFF_FFFC with no stall → wraps to 0.
- Force 2^16+3 stall cycles → stall_count=FFFF (saturated). Assert rst mid-stall → all outputs return to reset values the next cycle.
